// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed common-anode seven-segment scanner with frame snapshot
module seg7_scan_ctrl #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 100000,
   parameter int BLINK_DIV   = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blink_en,
   input  logic                    hex_mode,
   input  logic                    lz_suppress,
   output logic [NUM_DIGITS-1:0]   digit,
   output logic [6:0]              display,
   output logic                    dp,
   output logic                    frame_tick
);

   localparam int PW = $clog2(REFRESH_DIV);
   localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [PW-1:0]             presc;
   logic [SW-1:0]             slot;
   logic [BW-1:0]             bcnt;
   logic                      blink_phase;
   logic [4*NUM_DIGITS-1:0]   snap_bcd;
   logic [NUM_DIGITS-1:0]     snap_dp;
   logic [NUM_DIGITS-1:0]     snap_blink;
   logic                      snap_hex;
   logic                      snap_lz;
   logic                      snap_phase;

   logic                      tc;
   logic [SW-1:0]             next_slot;
   logic                      frame_start;
   logic [4*NUM_DIGITS-1:0]   cur_bcd;
   logic [NUM_DIGITS-1:0]     cur_dp;
   logic [NUM_DIGITS-1:0]     cur_blink;
   logic                      cur_hex;
   logic                      cur_lz;
   logic                      cur_phase;

   logic                      all_zero;
   logic [3:0]                nib;
   logic                      lz_sel;
   logic                      dp_sel;
   logic                      blink_sel;
   logic [NUM_DIGITS-1:0]     digit_nxt;
   logic [6:0]                seg_nxt;
   logic                      dp_nxt;

   function automatic logic [6:0] seg_decode(input logic [3:0] v, input logic hex);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'b0000001;
         4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;
         4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;
         4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;
         4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0000100;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b1100000;
         4'hC: s = 7'b0110001;
         4'hD: s = 7'b1000010;
         4'hE: s = 7'b0110000;
         4'hF: s = 7'b0111000;
      endcase
      if (v > 4'h9 && !hex)
         s = 7'b1111111;
      return s;
   endfunction

   assign tc          = (presc == PW'(REFRESH_DIV - 1));
   assign next_slot   = (slot == SW'(NUM_DIGITS - 1)) ? '0 : slot + SW'(1);
   assign frame_start = tc && (next_slot == '0);

   // On the capture edge slot 0 must already see the values being loaded.
   assign cur_bcd   = frame_start ? bcd_in      : snap_bcd;
   assign cur_dp    = frame_start ? dp_in       : snap_dp;
   assign cur_blink = frame_start ? blink_en    : snap_blink;
   assign cur_hex   = frame_start ? hex_mode    : snap_hex;
   assign cur_lz    = frame_start ? lz_suppress : snap_lz;
   assign cur_phase = frame_start ? blink_phase : snap_phase;

   always_comb begin
      all_zero  = 1'b1;
      nib       = 4'h0;
      lz_sel    = 1'b0;
      dp_sel    = 1'b0;
      blink_sel = 1'b0;
      digit_nxt = '1;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         all_zero     = all_zero & (cur_bcd[4*k +: 4] == 4'h0);
         digit_nxt[k] = (SW'(k) != next_slot);
         if (SW'(k) == next_slot) begin
            nib       = cur_bcd[4*k +: 4];
            lz_sel    = all_zero && (k != 0) && cur_lz;
            dp_sel    = cur_dp[k];
            blink_sel = cur_blink[k];
         end
      end
      seg_nxt = seg_decode(nib, cur_hex);
      dp_nxt  = ~dp_sel;
      if (blink_sel && cur_phase) begin
         seg_nxt = 7'b1111111;
         dp_nxt  = 1'b1;
      end else if (lz_sel) begin
         seg_nxt = 7'b1111111;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc       <= '0;
         slot        <= SW'(NUM_DIGITS - 1);
         bcnt        <= '0;
         blink_phase <= 1'b0;
         snap_bcd    <= '0;
         snap_dp     <= '0;
         snap_blink  <= '0;
         snap_hex    <= 1'b0;
         snap_lz     <= 1'b0;
         snap_phase  <= 1'b0;
         digit       <= '1;
         display     <= 7'b1111111;
         dp          <= 1'b1;
         frame_tick  <= 1'b0;
      end else begin
         frame_tick <= frame_start;
         if (tc) begin
            presc   <= '0;
            slot    <= next_slot;
            digit   <= digit_nxt;
            display <= seg_nxt;
            dp      <= dp_nxt;
         end else begin
            presc <= presc + PW'(1);
         end
         // The phase seen for a whole frame is the one in force before this frame's toggle.
         if (frame_start) begin
            snap_bcd   <= bcd_in;
            snap_dp    <= dp_in;
            snap_blink <= blink_en;
            snap_hex   <= hex_mode;
            snap_lz    <= lz_suppress;
            snap_phase <= blink_phase;
            if (bcnt == BW'(BLINK_DIV - 1)) begin
               bcnt        <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               bcnt <= bcnt + BW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - directed bench for seg7_scan_ctrl (4 digits, refresh 4, blink 2)
module tb_seg7_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] bcd_in;
   logic [3:0]  dp_in;
   logic [3:0]  blink_en;
   logic        hex_mode;
   logic        lz_suppress;
   logic [3:0]  digit;
   logic [6:0]  display;
   logic        dp;
   logic        frame_tick;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seg7_scan_ctrl #(
      .NUM_DIGITS (4),
      .REFRESH_DIV(4),
      .BLINK_DIV  (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bcd_in     (bcd_in),
      .dp_in      (dp_in),
      .blink_en   (blink_en),
      .hex_mode   (hex_mode),
      .lz_suppress(lz_suppress),
      .digit      (digit),
      .display    (display),
      .dp         (dp),
      .frame_tick (frame_tick)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_frame(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (frame_tick) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bit ok;
      rst_n = 1'b0; bcd_in = '0; dp_in = '0; blink_en = '0; hex_mode = 1'b0; lz_suppress = 1'b0;
      step(); step();
      checks++;
      if ({digit, display, dp, frame_tick} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset_init: got digit=%b display=%b dp=%b ft=%b, want 1111 1111111 1 0", digit, display, dp, frame_tick);
      end
      rst_n = 1'b1;
      wait_frame(ok);
      checks++;
      if (!ok || digit !== 4'b1110) begin
         errors++;
         $display("FAIL first_frame: ok=%0d digit=%b, want ok=1 digit=1110", ok, digit);
      end
      repeat (8) step();
      checks++;
      if (digit !== 4'b1011) begin
         errors++;
         $display("FAIL reach_slot2: digit=%b, want 1011", digit);
      end
      step();
      rst_n = 1'b0;
      step();
      checks++;
      if ({digit, display, dp, frame_tick} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset_midscan: got digit=%b display=%b dp=%b ft=%b, want 1111 1111111 1 0", digit, display, dp, frame_tick);
      end
      step();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         checks++;
         if (digit !== 4'b1111 || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL release_wait c%0d: digit=%b ft=%b, want 1111 0", c, digit, frame_tick);
         end
      end
      step();
      checks++;
      if (digit !== 4'b1110 || frame_tick !== 1'b1) begin
         errors++;
         $display("FAIL release_first: digit=%b ft=%b, want 1110 1", digit, frame_tick);
      end
   endtask

   task automatic test_scan_order();
      bit ok;
      logic [3:0] exp_dig [4];
      logic [6:0] exp_seg [4];
      exp_dig = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      exp_seg = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
      bcd_in = 16'h1234; hex_mode = 1'b0;
      wait_frame(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL scan_wait: no frame_tick, want one");
      end
      for (int s = 0; s < 4; s++) begin
         for (int c = 0; c < 4; c++) begin
            checks++;
            if ({digit, display, dp, frame_tick} !== {exp_dig[s], exp_seg[s], 1'b1, (s == 0 && c == 0)}) begin
               errors++;
               $display("FAIL scan s%0d c%0d: got %b %b dp=%b ft=%b, want %b %b dp=1 ft=%0d",
                        s, c, digit, display, dp, frame_tick, exp_dig[s], exp_seg[s], (s == 0 && c == 0));
            end
            step();
         end
      end
   endtask

   task automatic test_snapshot();
      logic [6:0] old_seg [4];
      logic [6:0] new_seg [4];
      old_seg = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
      new_seg = '{7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100};
      repeat (4) step();
      bcd_in = 16'h5678;
      for (int s = 1; s < 4; s++) begin
         checks++;
         if (display !== old_seg[s]) begin
            errors++;
            $display("FAIL snap_old s%0d: display=%b, want %b", s, display, old_seg[s]);
         end
         repeat (4) step();
      end
      for (int s = 0; s < 4; s++) begin
         checks++;
         if (display !== new_seg[s] || (s == 0 && frame_tick !== 1'b1)) begin
            errors++;
            $display("FAIL snap_new s%0d: display=%b ft=%b, want %b", s, display, frame_tick, new_seg[s]);
         end
         repeat (4) step();
      end
   endtask

   task automatic test_hex();
      bit ok;
      logic [6:0] exp_seg [4];
      exp_seg = '{7'b0111000, 7'b0110001, 7'b1100000, 7'b0001000};
      bcd_in = 16'hABCF; hex_mode = 1'b1;
      wait_frame(ok);
      for (int s = 0; s < 4; s++) begin
         checks++;
         if (!ok || display !== exp_seg[s]) begin
            errors++;
            $display("FAIL hex_on s%0d: ok=%0d display=%b, want %b", s, ok, display, exp_seg[s]);
         end
         repeat (4) step();
      end
      hex_mode = 1'b0;
      wait_frame(ok);
      for (int s = 0; s < 4; s++) begin
         checks++;
         if (!ok || display !== 7'b1111111) begin
            errors++;
            $display("FAIL hex_off s%0d: ok=%0d display=%b, want 1111111", s, ok, display);
         end
         repeat (4) step();
      end
   endtask

   task automatic test_lz();
      bit ok;
      logic [6:0] seg_a [4];
      logic [6:0] seg_b [4];
      logic       dp_exp [4];
      seg_a  = '{7'b0000001, 7'b0100100, 7'b1111111, 7'b1111111};
      seg_b  = '{7'b0000001, 7'b1111111, 7'b1111111, 7'b1111111};
      dp_exp = '{1'b1, 1'b1, 1'b0, 1'b1};
      lz_suppress = 1'b1; dp_in = 4'b0100; bcd_in = 16'h0050;
      wait_frame(ok);
      for (int s = 0; s < 4; s++) begin
         checks++;
         if (!ok || display !== seg_a[s] || dp !== dp_exp[s]) begin
            errors++;
            $display("FAIL lz_0050 s%0d: display=%b dp=%b, want %b %b", s, display, dp, seg_a[s], dp_exp[s]);
         end
         repeat (4) step();
      end
      bcd_in = 16'h0000;
      wait_frame(ok);
      for (int s = 0; s < 4; s++) begin
         checks++;
         if (!ok || display !== seg_b[s] || dp !== dp_exp[s]) begin
            errors++;
            $display("FAIL lz_0000 s%0d: display=%b dp=%b, want %b %b", s, display, dp, seg_b[s], dp_exp[s]);
         end
         repeat (4) step();
      end
   endtask

   task automatic test_blink();
      bit ok;
      logic [6:0] exp0;
      blink_en = 4'b0001; bcd_in = 16'h8888; lz_suppress = 1'b0; dp_in = 4'b0001; hex_mode = 1'b0;
      rst_n = 1'b0;
      step(); step();
      rst_n = 1'b1;
      for (int f = 0; f < 8; f++) begin
         wait_frame(ok);
         exp0 = (f % 4 >= 2) ? 7'b1111111 : 7'b0000000;
         checks++;
         if (!ok || display !== exp0 || dp !== (f % 4 >= 2)) begin
            errors++;
            $display("FAIL blink_d0 f%0d: display=%b dp=%b, want %b %0d", f, display, dp, exp0, (f % 4 >= 2));
         end
         repeat (4) step();
         checks++;
         if (digit !== 4'b1101 || display !== 7'b0000000) begin
            errors++;
            $display("FAIL blink_d1 f%0d: digit=%b display=%b, want 1101 0000000", f, digit, display);
         end
      end
   endtask

   initial begin
      test_reset();
      test_scan_order();
      test_snapshot();
      test_hex();
      test_lz();
      test_blink();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, want completion");
      $fatal(1);
   end

endmodule
